// File: rtl/keypad_pkg.sv
// keypad_pkg: key/display codes, scan FSM states and the 4x4 key layout.
// Pure constants; no latency or backpressure.
package keypad_pkg;

  localparam logic [3:0] KEY_CLEAR  = 4'hA;
  localparam logic [3:0] KEY_ENTER  = 4'hB;
  localparam logic [3:0] KEY_DELETE = 4'hC;
  localparam logic [3:0] KEY_NONE   = 4'hF;
  localparam logic [3:0] DISP_BLANK = 4'hF;
  localparam logic [3:0] DISP_MASK  = 4'hE;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } scan_state_e;

  // KEYMAP[row][col]; ascending packed ranges put row 0 / col 0 leftmost.
  localparam logic [0:3][0:3][3:0] KEYMAP = {16'h1470, 16'h258F, 16'h369B, 16'hFFAC};

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// keypad_scanner: one-hot-low row scan, press and release debounce, key mapping.
// key_strobe DEBOUNCE_CYCLES+1 cycles after the first stable sample; no backpressure, one strobe per press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int NUM_ROWS        = 4,
  parameter int NUM_COLS        = 4,
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic                clk_500Hz,
  input  logic                rst_n,
  input  logic [NUM_COLS-1:0] cols_n,
  output logic [NUM_ROWS-1:0] rows_n,
  output logic [3:0]          key_code,
  output logic                key_strobe
);

  localparam int RW   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int CIW  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int CNTW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNTW-1:0]     CNT_LAST  = CNTW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0]       ROW_LAST  = RW'(NUM_ROWS - 1);
  localparam logic [NUM_COLS-1:0] COLS_IDLE = '1;
  localparam logic [NUM_COLS-1:0] COLS_ONE  = NUM_COLS'(1);

  scan_state_e         state_q, state_d;
  logic [RW-1:0]       row_q, row_d;
  logic [NUM_COLS-1:0] pat_q, pat_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [3:0]          key_code_q, key_code_d;
  logic                key_strobe_q, key_strobe_d;

  logic                single_hot;
  logic [CIW-1:0]      col_idx;
  logic [3:0]          map_code;

  always_comb begin
    single_hot = (pat_q != COLS_IDLE) && (((~pat_q) & ((~pat_q) - COLS_ONE)) == '0);
    col_idx    = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (!pat_q[c]) col_idx = CIW'(c);
    end
  end

  generate
    if (NUM_ROWS == 4 && NUM_COLS == 4) begin : g_map4
      assign map_code = KEYMAP[row_q][col_idx];
    end else begin : g_maplin
      int lin;
      always_comb begin
        lin      = int'(row_q) * NUM_COLS + int'(col_idx);
        map_code = (lin > 15) ? KEY_NONE : lin[3:0];
      end
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    pat_d        = pat_q;
    cnt_d        = cnt_q;
    key_code_d   = key_code_q;
    key_strobe_d = 1'b0;
    case (state_q)
      SCAN: begin
        if (cols_n == COLS_IDLE) begin
          row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end else begin
          pat_d   = cols_n;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        // Multi-column patterns park here at the final count until they change.
        if (cols_n != pat_q) begin
          state_d = SCAN;
        end else if (cnt_q == CNT_LAST) begin
          if (single_hot) begin
            state_d      = HELD;
            key_strobe_d = 1'b1;
            key_code_d   = map_code;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (cols_n == COLS_IDLE) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
      end
      RELEASE: begin
        if (cols_n != COLS_IDLE) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = SCAN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk_500Hz or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SCAN;
      row_q        <= '0;
      pat_q        <= '1;
      cnt_q        <= '0;
      key_code_q   <= KEY_NONE;
      key_strobe_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      pat_q        <= pat_d;
      cnt_q        <= cnt_d;
      key_code_q   <= key_code_d;
      key_strobe_q <= key_strobe_d;
    end
  end

  assign rows_n     = ~(NUM_ROWS'(1) << row_q);
  assign key_code   = key_code_q;
  assign key_strobe = key_strobe_q;

endmodule

// File: rtl/keypad_pin_entry.sv
// keypad_pin_entry: keypad scanner plus PIN buffer with clear/delete/enter, idle timeout, masked display.
// Entry outputs update one cycle after key_strobe; no backpressure, every accepted key is processed.
module keypad_pin_entry
  import keypad_pkg::*;
#(
  parameter int NUM_ROWS        = 4,
  parameter int NUM_COLS        = 4,
  parameter int PIN_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int IDLE_TIMEOUT    = 2500
) (
  input  logic                            clk_500Hz,
  input  logic                            rst_n,
  input  logic [NUM_COLS-1:0]             cols_n,
  input  logic                            mask_en,
  output logic [NUM_ROWS-1:0]             rows_n,
  output logic [3:0]                      key_code,
  output logic                            key_strobe,
  output logic [$clog2(PIN_DIGITS+1)-1:0] digit_count,
  output logic [4*PIN_DIGITS-1:0]         pin_disp,
  output logic [4*PIN_DIGITS-1:0]         pin_value,
  output logic                            pin_valid,
  output logic                            entry_error,
  output logic                            entry_timeout
);

  localparam int CW = $clog2(PIN_DIGITS + 1);
  localparam int TW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] COUNT_FULL = CW'(PIN_DIGITS);
  localparam logic [TW-1:0] IDLE_LAST  = TW'(IDLE_TIMEOUT - 1);

  logic [PIN_DIGITS-1:0][3:0] digits_q, digits_d;
  logic [CW-1:0]              count_q, count_d;
  logic [TW-1:0]              idle_q, idle_d;
  logic [4*PIN_DIGITS-1:0]    pin_value_q, pin_value_d;
  logic                       pin_valid_q, pin_valid_d;
  logic                       error_q, error_d;
  logic                       timeout_q, timeout_d;
  logic [4*PIN_DIGITS-1:0]    pin_packed;
  logic [4*PIN_DIGITS-1:0]    disp;

  keypad_scanner #(
    .NUM_ROWS        (NUM_ROWS),
    .NUM_COLS        (NUM_COLS),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_scanner (
    .clk_500Hz  (clk_500Hz),
    .rst_n      (rst_n),
    .cols_n     (cols_n),
    .rows_n     (rows_n),
    .key_code   (key_code),
    .key_strobe (key_strobe)
  );

  // First digit entered lands in the most significant nibble of the PIN.
  always_comb begin
    pin_packed = '0;
    disp       = '0;
    for (int i = 0; i < PIN_DIGITS; i++) begin
      pin_packed[4*(PIN_DIGITS-1-i) +: 4] = digits_q[i];
      disp[4*i +: 4] = (CW'(i) < count_q) ? (mask_en ? DISP_MASK : digits_q[i]) : DISP_BLANK;
    end
  end

  always_comb begin
    digits_d    = digits_q;
    count_d     = count_q;
    idle_d      = idle_q;
    pin_value_d = pin_value_q;
    pin_valid_d = 1'b0;
    error_d     = 1'b0;
    timeout_d   = 1'b0;
    if (key_strobe) begin
      idle_d = '0;
      if (is_digit(key_code)) begin
        if (count_q < COUNT_FULL) begin
          for (int i = 0; i < PIN_DIGITS; i++) begin
            if (CW'(i) == count_q) digits_d[i] = key_code;
          end
          count_d = count_q + 1'b1;
        end else begin
          error_d = 1'b1;
        end
      end else begin
        case (key_code)
          KEY_CLEAR:  count_d = '0;
          KEY_DELETE: if (count_q != '0) count_d = count_q - 1'b1;
          KEY_ENTER: begin
            if (count_q == COUNT_FULL) begin
              pin_value_d = pin_packed;
              pin_valid_d = 1'b1;
              count_d     = '0;
            end else begin
              error_d = 1'b1;
            end
          end
          default: error_d = 1'b1;
        endcase
      end
    end else if (IDLE_TIMEOUT != 0 && count_q != '0) begin
      if (idle_q == IDLE_LAST) begin
        count_d   = '0;
        timeout_d = 1'b1;
        idle_d    = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_500Hz or negedge rst_n) begin
    if (!rst_n) begin
      digits_q    <= '0;
      count_q     <= '0;
      idle_q      <= '0;
      pin_value_q <= '0;
      pin_valid_q <= 1'b0;
      error_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      digits_q    <= digits_d;
      count_q     <= count_d;
      idle_q      <= idle_d;
      pin_value_q <= pin_value_d;
      pin_valid_q <= pin_valid_d;
      error_q     <= error_d;
      timeout_q   <= timeout_d;
    end
  end

  assign digit_count   = count_q;
  assign pin_disp      = disp;
  assign pin_value     = pin_value_q;
  assign pin_valid     = pin_valid_q;
  assign entry_error   = error_q;
  assign entry_timeout = timeout_q;

endmodule

// File: tb/tb_keypad_pin_entry.sv
// Directed bench for keypad_pin_entry: a behavioural keypad drives both instances,
// u_dut with the default idle timeout and u_dut_to with a 50-cycle timeout.
module tb_keypad_pin_entry;

  localparam int D = 20;
  localparam int T = 50;

  logic       clk_500Hz = 1'b0;
  logic       rst_n;
  logic       mask_en;
  logic       pressed;
  logic [1:0] prow, pcol;
  logic       ovr_en;
  logic [3:0] ovr_pat;

  logic [3:0]  rows_n, cols_n, key_code;
  logic        key_strobe, pin_valid, entry_error, entry_timeout;
  logic [2:0]  digit_count;
  logic [15:0] pin_disp, pin_value;

  logic [3:0]  rows2_n, cols2_n, key_code2;
  logic        key_strobe2, pin_valid2, entry_error2, entry_timeout2;
  logic [2:0]  digit_count2;
  logic [15:0] pin_disp2, pin_value2;

  int n_checks = 0;
  int n_fail   = 0;
  int n_strobe = 0;
  int n_valid  = 0;
  int n_err    = 0;
  int n_to     = 0;

  always #5 clk_500Hz = ~clk_500Hz;

  keypad_pin_entry #(.DEBOUNCE_CYCLES(D)) u_dut (
    .clk_500Hz(clk_500Hz), .rst_n(rst_n), .cols_n(cols_n), .mask_en(mask_en),
    .rows_n(rows_n), .key_code(key_code), .key_strobe(key_strobe),
    .digit_count(digit_count), .pin_disp(pin_disp), .pin_value(pin_value),
    .pin_valid(pin_valid), .entry_error(entry_error), .entry_timeout(entry_timeout)
  );

  keypad_pin_entry #(.DEBOUNCE_CYCLES(D), .IDLE_TIMEOUT(T)) u_dut_to (
    .clk_500Hz(clk_500Hz), .rst_n(rst_n), .cols_n(cols2_n), .mask_en(mask_en),
    .rows_n(rows2_n), .key_code(key_code2), .key_strobe(key_strobe2),
    .digit_count(digit_count2), .pin_disp(pin_disp2), .pin_value(pin_value2),
    .pin_valid(pin_valid2), .entry_error(entry_error2), .entry_timeout(entry_timeout2)
  );

  // Pressed key pulls its column low only while its row is driven.
  always_comb begin
    cols_n = 4'hF;
    if (ovr_en) cols_n = ovr_pat;
    else if (pressed && !rows_n[prow]) cols_n[pcol] = 1'b0;
  end

  always_comb begin
    cols2_n = 4'hF;
    if (ovr_en) cols2_n = ovr_pat;
    else if (pressed && !rows2_n[prow]) cols2_n[pcol] = 1'b0;
  end

  always @(negedge clk_500Hz) begin
    if (key_strobe)    n_strobe++;
    if (pin_valid)     n_valid++;
    if (entry_error)   n_err++;
    if (entry_timeout) n_to++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_key(input logic [3:0] code);
    case (code)
      4'h1: begin prow = 2'd0; pcol = 2'd0; end
      4'h4: begin prow = 2'd0; pcol = 2'd1; end
      4'h7: begin prow = 2'd0; pcol = 2'd2; end
      4'h0: begin prow = 2'd0; pcol = 2'd3; end
      4'h2: begin prow = 2'd1; pcol = 2'd0; end
      4'h5: begin prow = 2'd1; pcol = 2'd1; end
      4'h8: begin prow = 2'd1; pcol = 2'd2; end
      4'h3: begin prow = 2'd2; pcol = 2'd0; end
      4'h6: begin prow = 2'd2; pcol = 2'd1; end
      4'h9: begin prow = 2'd2; pcol = 2'd2; end
      4'hB: begin prow = 2'd2; pcol = 2'd3; end
      4'hA: begin prow = 2'd3; pcol = 2'd2; end
      4'hC: begin prow = 2'd3; pcol = 2'd3; end
      default: begin prow = 2'd3; pcol = 2'd0; end
    endcase
  endtask

  task automatic press_key(input logic [3:0] code);
    logic seen;
    seen = 1'b0;
    set_key(code);
    pressed = 1'b1;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk_500Hz);
      if (key_strobe) seen = 1'b1;
    end
    check("strobe_seen", {31'd0, seen}, 32'd1);
    repeat (2) @(negedge clk_500Hz);
    pressed = 1'b0;
    repeat (2*D + 4) @(negedge clk_500Hz);
  endtask

  task automatic check_reset_values();
    check("rst_rows_n", {28'd0, rows_n}, 32'hE);
    check("rst_key_code", {28'd0, key_code}, 32'hF);
    check("rst_key_strobe", {31'd0, key_strobe}, 32'd0);
    check("rst_digit_count", {29'd0, digit_count}, 32'd0);
    check("rst_pin_disp", {16'd0, pin_disp}, 32'hFFFF);
    check("rst_pin_value", {16'd0, pin_value}, 32'd0);
    check("rst_flags", {29'd0, pin_valid, entry_error, entry_timeout}, 32'd0);
  endtask

  initial begin
    int lat, s0, e0, v0;
    logic found;
    rst_n = 1'b0; mask_en = 1'b0; pressed = 1'b0;
    prow = 2'd0; pcol = 2'd0; ovr_en = 1'b0; ovr_pat = 4'hF;
    repeat (3) @(negedge clk_500Hz);
    check_reset_values();

    // Key '1' held across reset release: one strobe at D+1 sampled cycles.
    set_key(4'h1);
    pressed = 1'b1;
    @(negedge clk_500Hz);
    rst_n = 1'b1;
    lat = 0;
    for (int n = 1; n <= 60 && lat == 0; n++) begin
      @(negedge clk_500Hz);
      if (key_strobe) lat = n;
    end
    check("press_latency", lat, D + 1);
    check("press_code", {28'd0, key_code}, 32'h1);
    repeat (2) @(negedge clk_500Hz);
    pressed = 1'b0;
    repeat (2*D + 4) @(negedge clk_500Hz);
    check("held_reset_strobes", n_strobe, 1);
    check("held_reset_disp", {16'd0, pin_disp}, 32'hFFF1);
    press_key(4'hA);
    check("clear_count", {29'd0, digit_count}, 32'd0);

    // Row1/col0 for 30 cycles, then a 5-cycle bounce during release.
    s0 = n_strobe;
    set_key(4'h2);
    pressed = 1'b1; repeat (30) @(negedge clk_500Hz);
    pressed = 1'b0; repeat (3)  @(negedge clk_500Hz);
    pressed = 1'b1; repeat (5)  @(negedge clk_500Hz);
    pressed = 1'b0; repeat (2*D + 10) @(negedge clk_500Hz);
    check("bounce_strobes", n_strobe - s0, 1);
    check("bounce_code", {28'd0, key_code}, 32'h2);
    press_key(4'hA);

    // 1,2,3,4 ENTER
    e0 = n_err;
    v0 = n_valid;
    press_key(4'h1); press_key(4'h2); press_key(4'h3); press_key(4'h4);
    check("disp_1234", {16'd0, pin_disp}, 32'h4321);
    mask_en = 1'b1;
    #1;
    check("disp_masked", {16'd0, pin_disp}, 32'hEEEE);
    mask_en = 1'b0;
    press_key(4'hB);
    check("enter_valid", n_valid - v0, 1);
    check("enter_value", {16'd0, pin_value}, 32'h1234);
    check("enter_count", {29'd0, digit_count}, 32'd0);

    // 5,6,DELETE,7,CLEAR,DELETE
    press_key(4'h5); press_key(4'h6); press_key(4'hC); press_key(4'h7);
    check("edit_disp", {16'd0, pin_disp}, 32'hFF75);
    check("edit_count", {29'd0, digit_count}, 32'd2);
    press_key(4'hA);
    check("edit_clear_disp", {16'd0, pin_disp}, 32'hFFFF);
    press_key(4'hC);
    check("edit_del_empty", {29'd0, digit_count}, 32'd0);
    check("edit_no_error", n_err - e0, 0);

    // Short ENTER, overflow digits, unmapped key
    press_key(4'h1); press_key(4'h2); press_key(4'h3); press_key(4'hB);
    check("short_enter_err", n_err - e0, 1);
    check("short_enter_count", {29'd0, digit_count}, 32'd3);
    press_key(4'h4); press_key(4'h5); press_key(4'h6);
    check("overflow_err", n_err - e0, 3);
    check("overflow_count", {29'd0, digit_count}, 32'd4);
    check("overflow_disp", {16'd0, pin_disp}, 32'h4321);
    press_key(4'hF);
    check("unmapped_err", n_err - e0, 4);
    press_key(4'hB);
    check("resubmit_valid", n_valid - v0, 2);
    check("resubmit_value", {16'd0, pin_value}, 32'h1234);

    // Idle timeout on u_dut_to: T cycles after digit_count becomes 1.
    rst_n = 1'b0;
    @(negedge clk_500Hz);
    rst_n = 1'b1;
    @(negedge clk_500Hz);
    set_key(4'h9);
    pressed = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      @(negedge clk_500Hz);
      if (digit_count2 == 3'd1) found = 1'b1;
    end
    check("to_digit_seen", {31'd0, found}, 32'd1);
    pressed = 1'b0;
    lat = 0;
    for (int n = 1; n <= 200 && lat == 0; n++) begin
      @(negedge clk_500Hz);
      if (entry_timeout2) lat = n;
    end
    check("timeout_latency", lat, T);
    @(negedge clk_500Hz);
    check("timeout_count", {29'd0, digit_count2}, 32'd0);
    check("timeout_disp", {16'd0, pin_disp2}, 32'hFFFF);
    check("no_timeout_main", {29'd0, digit_count}, 32'd1);
    check("no_timeout_pulse", n_to, 0);

    // Two columns low: never accepted; then reset mid-debounce.
    s0 = n_strobe;
    ovr_en = 1'b1;
    ovr_pat = 4'b1100;
    repeat (100) @(negedge clk_500Hz);
    check("multi_col_strobes", n_strobe - s0, 0);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    ovr_en = 1'b0;
    @(negedge clk_500Hz);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_500Hz);

    $display("Result: errors=%0d of %0d checks", n_fail, n_checks);
    $finish;
  end

endmodule
